// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : ALUOp encodings and the multiply sequencer state type.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer : shift-add multiplier borrowing the shared EX-stage ALU.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            busy
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  seq_state_e       state_q, state_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_step;

  // Early exit looks ahead: once the bits still to be shifted in are all zero,
  // the current step is the last one that can change the accumulator.
  always_comb begin
    last_step = (cnt_q == CNT_W'(XLEN - 1)) ||
                (EARLY_EXIT && ((mplier_q >> 1) == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    start_ready  = 1'b0;
    busy         = 1'b1;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = ALU_AND;
    result       = '0;
    result_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        alu_op   = ALU_ADD;
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result       = acc_q;
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer : randomized self-checking bench, both EARLY_EXIT modes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sv1, sv0;
  logic [63:0] op_a, op_b;
  logic        result_ready;

  logic        sr1, rv1, busy1, sr0, rv0, busy0;
  logic [63:0] aa1, ab1, res1, alu_r1, aa0, ab0, res0, alu_r0;
  logic [3:0]  ao1, ao0;

  bit          sel;
  logic        sr, rv, bsy;
  logic [63:0] ab, res;
  logic [3:0]  ao;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_NOR: return ~(a | b);
      default: return 64'd0;
    endcase
  endfunction

  assign alu_r1 = alu_f(aa1, ab1, ao1);
  assign alu_r0 = alu_f(aa0, ab0, ao0);

  alu_mul_sequencer #(.XLEN(64), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(sr1),
    .op_a(op_a), .op_b(op_b), .alu_a(aa1), .alu_b(ab1), .alu_op(ao1),
    .alu_result(alu_r1), .result(res1), .result_valid(rv1),
    .result_ready(result_ready), .busy(busy1));

  alu_mul_sequencer #(.XLEN(64), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset), .start_valid(sv0), .start_ready(sr0),
    .op_a(op_a), .op_b(op_b), .alu_a(aa0), .alu_b(ab0), .alu_op(ao0),
    .alu_result(alu_r0), .result(res0), .result_valid(rv0),
    .result_ready(result_ready), .busy(busy0));

  assign sr  = sel ? sr0   : sr1;
  assign rv  = sel ? rv0   : rv1;
  assign bsy = sel ? busy0 : busy1;
  assign ab  = sel ? ab0   : ab1;
  assign res = sel ? res0  : res1;
  assign ao  = sel ? ao0   : ao1;

  // Reference: number of add steps is the multiplier's bit length (min 1),
  // or the full word when early exit is disabled.
  function automatic int exp_runs(input logic [63:0] b, input bit ee);
    if (!ee) return 64;
    for (int i = 63; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output int runs, output int lat,
                        output int bmis);
    logic [63:0] exp_b;
    @(negedge clk);
    op_a = a; op_b = b;
    if (sel) sv0 = 1'b1; else sv1 = 1'b1;
    n_cmp++;
    if (sr !== 1'b1) begin
      n_err++;
      $display("FAIL start_ready_before_accept: got %b want 1", sr);
    end
    @(posedge clk); #1;
    sv0 = 1'b0; sv1 = 1'b0;
    op_a = rand64(); op_b = rand64();
    runs = 0; lat = 0; bmis = 0; r = 'x;
    repeat (100) begin
      @(negedge clk);
      lat++;
      if (rv === 1'b1) break;
      if (ao === ALU_ADD) begin
        exp_b = (runs < 64 && b[runs]) ? (a << runs) : 64'd0;
        if (ab !== exp_b) bmis++;
        runs++;
      end
    end
    if (rv === 1'b1) r = res;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic check_mul(input string name, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r, want;
    int runs, lat, bmis, wruns;
    want  = a * b;
    wruns = exp_runs(b, !sel);
    do_mul(a, b, r, runs, lat, bmis);
    n_cmp++;
    if (r !== want) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, r, want);
    end
    n_cmp++;
    if (runs != wruns) begin
      n_err++;
      $display("FAIL %s run_cycles: got %0d want %0d", name, runs, wruns);
    end
    n_cmp++;
    if (lat != wruns + 1) begin
      n_err++;
      $display("FAIL %s valid_latency: got %0d want %0d", name, lat, wruns + 1);
    end
    n_cmp++;
    if (bmis != 0) begin
      n_err++;
      $display("FAIL %s alu_b_sequence: got %0d bad steps want 0", name, bmis);
    end
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (sr1 !== 1'b1 || busy1 !== 1'b0 || rv1 !== 1'b0 || res1 !== 64'd0 ||
        aa1 !== 64'd0 || ab1 !== 64'd0 || ao1 !== 4'd0) begin
      n_err++;
      $display("FAIL %s: got sr=%b busy=%b rv=%b res=%h a=%h b=%h op=%h want 1 0 0 0 0 0 0",
               name, sr1, busy1, rv1, res1, aa1, ab1, ao1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sv1 = 1'b0; sv0 = 1'b0; result_ready = 1'b0;
    op_a = 64'd0; op_b = 64'd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");
    n_cmp++;
    if (sr0 !== 1'b1 || busy0 !== 1'b0 || rv0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state_full: got sr=%b busy=%b rv=%b want 1 0 0", sr0, busy0, rv0);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    sel = 1'b0;
    check_mul("3x5", 64'd3, 64'd5);
    check_mul("opb_zero", 64'h1234, 64'd0);
    check_mul("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check_mul("opb_msb", rand64(), 64'h8000_0000_0000_0000);
  endtask

  task automatic test_random_early();
    sel = 1'b0;
    for (int i = 0; i < 10; i++) check_mul("rand_early", rand64(), rand64() >> $urandom_range(0, 63));
  endtask

  task automatic test_no_early_exit();
    sel = 1'b1;
    check_mul("full_2x3", 64'd2, 64'd3);
    for (int i = 0; i < 3; i++) check_mul("rand_full", rand64(), rand64() >> $urandom_range(0, 63));
    sel = 1'b0;
  endtask

  task automatic test_hold_and_handoff();
    int k;
    sel = 1'b0;
    @(negedge clk);
    op_a = 64'd7; op_b = 64'd9; sv1 = 1'b1;
    @(posedge clk); #1;
    sv1 = 1'b0;
    k = 0;
    while (rv1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (rv1 !== 1'b1 || res1 !== 64'd63) begin
      n_err++;
      $display("FAIL hold_first_result: got rv=%b res=%h want 1 %h", rv1, res1, 64'd63);
    end
    op_a = 64'd11; op_b = 64'd6; sv1 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (rv1 !== 1'b1 || res1 !== 64'd63 || sr1 !== 1'b0 || busy1 !== 1'b1) begin
        n_err++;
        $display("FAIL hold_stable: got rv=%b res=%h sr=%b busy=%b want 1 %h 0 1",
                 rv1, res1, sr1, busy1, 64'd63);
      end
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sr1 !== 1'b1 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL handoff_not_same_cycle: got sr=%b busy=%b want 1 0", sr1, busy1);
    end
    @(posedge clk); #1;
    sv1 = 1'b0;
    op_a = rand64(); op_b = rand64();
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b1 || sr1 !== 1'b0) begin
      n_err++;
      $display("FAIL handoff_accept: got busy=%b sr=%b want 1 0", busy1, sr1);
    end
    k = 0;
    while (rv1 !== 1'b1 && k < 80) begin @(negedge clk); k++; end
    n_cmp++;
    if (rv1 !== 1'b1 || res1 !== 64'd66) begin
      n_err++;
      $display("FAIL handoff_result: got rv=%b res=%h want 1 %h", rv1, res1, 64'd66);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int k, runs;
    sel = 1'b0;
    @(negedge clk);
    op_a = rand64(); op_b = 64'hFFFF_FFFF_FFFF_FFFF; sv1 = 1'b1;
    @(posedge clk); #1;
    sv1 = 1'b0;
    runs = 0; k = 0;
    while (runs < 10 && k < 40) begin
      @(negedge clk);
      k++;
      if (ao1 === ALU_ADD) runs++;
    end
    n_cmp++;
    if (runs != 10) begin
      n_err++;
      $display("FAIL midrun_reach: got %0d run cycles want 10", runs);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("midrun_reset");
    k = 0;
    repeat (70) begin
      @(negedge clk);
      if (rv1 !== 1'b0 || busy1 !== 1'b0) k++;
    end
    n_cmp++;
    if (k != 0) begin
      n_err++;
      $display("FAIL midrun_discard: got %0d cycles active want 0", k);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_early();
    test_no_early_exit();
    test_hold_and_handoff();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Iterative shift-add multiplier controller that sequences the shared 64-bit ALU to compute the low XLEN bits of a product. It sits beside the EX stage: it accepts an operand pair via valid/ready, drives the ALU's a/b/ALUOp inputs one accumulate step per cycle, and returns the product via valid/ready. It asserts `busy` so the hazard unit stalls the pipeline while it owns the ALU.

## Interface
- `XLEN`, default 64: operand, ALU and result width.
- `EARLY_EXIT`, default 1: when 1, stop iterating as soon as the remaining multiplier bits are zero.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start_valid` in 1: operand pair present.
- `start_ready` out 1: sequencer can accept; equals (state==IDLE).
- `op_a` in XLEN: multiplicand.
- `op_b` in XLEN: multiplier.
- `alu_a` out XLEN: ALU input a.
- `alu_b` out XLEN: ALU input b.
- `alu_op` out 4: ALUOp to the ALU.
- `alu_result` in XLEN: combinational ALU Result, valid in the same cycle.
- `result` out XLEN: product, low XLEN bits.
- `result_valid` out 1: product available.
- `result_ready` in 1: consumer takes product.
- `busy` out 1: (state!=IDLE), stall request.

## Operation
- States: IDLE, RUN, DONE. Registers: `acc`, `mcand`, `mplier` (XLEN each), `cnt` (clog2(XLEN) bits).
- IDLE:
  - On `start_valid & start_ready`: `acc`<=0, `mcand`<=op_a, `mplier`<=op_b, `cnt`<=0, go to RUN.
- RUN, once per cycle:
  - Drive `alu_a`=acc, `alu_op`=4'b0010 (ADD), `alu_b`=mplier[0] ? mcand : 0.
  - Update `acc`<=alu_result, `mcand`<=mcand<<1, `mplier`<=mplier>>1, `cnt`<=cnt+1.
- Exit RUN to DONE when either condition holds:
  - `cnt`==XLEN-1, or
  - EARLY_EXIT=1 and (mplier>>1)==0.
- DONE:
  - `result`=acc, `result_valid`=1.
  - On `result_ready`, go to IDLE.
- Outside RUN, drive `alu_a`=0, `alu_b`=0, `alu_op`=4'b0000.
- Arithmetic:
  - Sums wrap modulo 2^XLEN; no carry-out is kept.
  - The low-half product is identical for signed and unsigned operands, so there is no sign handling.
- Reset values: state IDLE, `start_ready`=1, `busy`=0, `result_valid`=0, `result`=0, `alu_a`=`alu_b`=0, `alu_op`=0, all internal registers 0.

## Timing
- Accept at edge N puts the sequencer in RUN from cycle N+1.
- Number of RUN cycles:
  - EARLY_EXIT=1: (index of highest set bit of op_b)+1, minimum 1 (op_b=0 gives 1).
  - EARLY_EXIT=0: always XLEN.
- `result_valid` rises the cycle after the last RUN cycle and holds, with `result` stable, until `result_ready`.
- Handshake rules:
  - `start_ready` is low in RUN and DONE.
  - A start that coincides with the DONE→IDLE handoff is accepted one cycle later, never in the same cycle.
  - `op_a`/`op_b` are sampled only on the accept edge; later changes are ignored.
- `reset` asserted in any state returns to IDLE at that edge. Any in-flight or pending result is discarded and `result_valid` is 0 the next cycle.
- `busy` is registered-state-derived, high from cycle N+1 through the DONE cycle that sees `result_ready`.

## Structure
- Shared package `alu_pkg`:
  - ALUOp constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_NOR=4'b1100, ALU_SLL=4'b1000.
  - The sequencer state enum (IDLE/RUN/DONE).
- No sub-module. The ALU is instantiated one level up and muxed to the sequencer while `busy`=1.

## Test plan
- op_a=3, op_b=5, EARLY_EXIT=1 → 3 RUN cycles (ALU b sequence 3,0,12), `result`=15, `result_valid` at N+4.
- op_a=0x1234, op_b=0 → 1 RUN cycle, `result`=0, `result_valid` at N+2.
- op_a=op_b=0xFFFF_FFFF_FFFF_FFFF → 64 RUN cycles, `result`=1 (wrap).
- `result_ready` held low 5 cycles in DONE with `start_valid`=1 → `result` stable, `start_ready`=0, `busy`=1. After `result_ready`, the new start is accepted the following cycle.
- `reset` high on the 10th RUN cycle → next cycle state IDLE, `result_valid`=0, `start_ready`=1, ALU ports 0.
- EARLY_EXIT=0, op_a=2, op_b=3 → exactly 64 RUN cycles, `result`=6.
